// File: rtl/exibe_sequencia_pkg.sv
// rtl/exibe_sequencia_pkg.sv - shared state codes and timing defaults for the Genius playback engine
package exibe_sequencia_pkg;

   localparam logic [2:0] OCIOSO   = 3'd0;
   localparam logic [2:0] ENDERECA = 3'd1;
   localparam logic [2:0] LE       = 3'd2;
   localparam logic [2:0] ACESO    = 3'd3;
   localparam logic [2:0] APAGADO  = 3'd4;
   localparam logic [2:0] FIM      = 3'd5;

   // Board-clock defaults, also used by the control unit's inactivity timer
   localparam int ON_CYCLES_PADRAO  = 1000;
   localparam int OFF_CYCLES_PADRAO = 500;

   function automatic int largura_tempo(input int on_c, input int off_c);
      int m;
      m = (on_c > off_c) ? on_c : off_c;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/exibe_sequencia_contador.sv
// rtl/exibe_sequencia_contador.sv - modulo up-counter used as the ON/OFF timer
module contador_tempo #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         zera,
   input  logic         conta,
   input  logic [W-1:0] limite,
   output logic         fim
);

   logic [W-1:0] valor;

   // limite is modulo-1, so the count wraps to 0 on its own when fim is seen
   always_ff @(posedge clock) begin
      if (!reset || zera) begin
         valor <= '0;
      end else if (conta) begin
         if (valor == limite) valor <= '0;
         else                 valor <= valor + 1'b1;
      end
   end

   assign fim = (valor == limite);

endmodule

// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - reads the colour sequence from RAM and shows it on the LEDs
import exibe_sequencia_pkg::*;

module exibe_sequencia #(
   parameter int DATA_W     = 4,
   parameter int ADDR_W     = 4,
   parameter int ON_CYCLES  = ON_CYCLES_PADRAO,
   parameter int OFF_CYCLES = OFF_CYCLES_PADRAO
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic [ADDR_W-1:0] ultimo_endereco,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dado,
   output logic [DATA_W-1:0] leds,
   output logic              ocupado,
   output logic              fim,
   output logic [2:0]        db_estado
);

   localparam int TW = largura_tempo(ON_CYCLES, OFF_CYCLES);
   localparam logic [TW-1:0] LIM_ON  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] LIM_OFF = TW'(OFF_CYCLES - 1);

   logic [2:0]        estado;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] ult_r;
   logic [DATA_W-1:0] cor_r;
   logic              zera_tempo;
   logic              conta_tempo;
   logic              fim_tempo;
   logic [TW-1:0]     limite_tempo;

   assign zera_tempo   = (estado == OCIOSO) || (estado == LE);
   assign conta_tempo  = (estado == ACESO) || (estado == APAGADO);
   assign limite_tempo = (estado == ACESO) ? LIM_ON : LIM_OFF;

   contador_tempo #(.W(TW)) u_tempo (
      .clock  (clock),
      .reset  (reset),
      .zera   (zera_tempo),
      .conta  (conta_tempo),
      .limite (limite_tempo),
      .fim    (fim_tempo)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado <= OCIOSO;
         addr_r <= '0;
         ult_r  <= '0;
         cor_r  <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (iniciar) begin
                  ult_r  <= ultimo_endereco;
                  addr_r <= '0;
                  estado <= ENDERECA;
               end
            end
            ENDERECA: estado <= LE;
            LE: begin
               cor_r  <= mem_dado;
               estado <= ACESO;
            end
            ACESO: begin
               if (fim_tempo) estado <= APAGADO;
            end
            APAGADO: begin
               // compare before incrementing so the last address never wraps
               if (fim_tempo) begin
                  if (addr_r == ult_r) begin
                     estado <= FIM;
                  end else begin
                     addr_r <= addr_r + 1'b1;
                     estado <= ENDERECA;
                  end
               end
            end
            FIM:     estado <= OCIOSO;
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign mem_addr  = addr_r;
   assign leds      = (estado == ACESO) ? cor_r : '0;
   assign ocupado   = (estado != OCIOSO);
   assign fim       = (estado == FIM);
   assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// tb/tb_exibe_sequencia.sv - self-checking bench for exibe_sequencia
module tb_exibe_sequencia;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PER = 2 + ON + OFF;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar;
   logic [3:0] ultimo_endereco;
   logic [3:0] mem_addr;
   logic [3:0] mem_dado;
   logic [3:0] leds;
   logic       ocupado;
   logic       fim;
   logic [2:0] db_estado;

   logic [3:0] ram [16];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0] leds;
      logic       fim;
      logic       ocup;
      logic [3:0] addr;
   } exp_t;

   exp_t sb[$];

   exibe_sequencia #(
      .DATA_W(4), .ADDR_W(4), .ON_CYCLES(ON), .OFF_CYCLES(OFF)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .iniciar         (iniciar),
      .ultimo_endereco (ultimo_endereco),
      .mem_addr        (mem_addr),
      .mem_dado        (mem_dado),
      .leds            (leds),
      .ocupado         (ocupado),
      .fim             (fim),
      .db_estado       (db_estado)
   );

   always #5 clock = ~clock;

   always @(posedge clock) mem_dado <= ram[mem_addr];

   // Start a playback at a negedge, push the per-cycle expectations, then score cycle by cycle.
   task automatic play(input string nome, input int ult, input bit hold,
                       input int chg_cycle, input logic [3:0] chg_val);
      int n;
      int last;
      exp_t e;
      n    = ult + 1;
      last = n * PER + 1;
      for (int c = 1; c <= last + 1; c++) begin
         int ent;
         int ph;
         ent = (c - 1) / PER;
         ph  = (c - 1) % PER;
         e.leds = (c < last && ph >= 2 && ph < 2 + ON) ? ram[ent] : 4'd0;
         e.fim  = (c == last);
         e.ocup = (c <= last);
         e.addr = (c < last) ? 4'(ent) : 4'(ult);
         sb.push_back(e);
      end
      ultimo_endereco = 4'(ult);
      iniciar = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (!hold) iniciar = 1'b0;
      for (int c = 1; c <= last + 1; c++) begin
         e = sb.pop_front();
         total++;
         if (leds !== e.leds) begin
            bad++;
            $display("FAIL %s leds cycle %0d: got %b want %b", nome, c, leds, e.leds);
         end
         total++;
         if (fim !== e.fim) begin
            bad++;
            $display("FAIL %s fim cycle %0d: got %b want %b", nome, c, fim, e.fim);
         end
         total++;
         if (ocupado !== e.ocup) begin
            bad++;
            $display("FAIL %s ocupado cycle %0d: got %b want %b", nome, c, ocupado, e.ocup);
         end
         total++;
         if (mem_addr !== e.addr) begin
            bad++;
            $display("FAIL %s mem_addr cycle %0d: got %0d want %0d", nome, c, mem_addr, e.addr);
         end
         if (c == chg_cycle) ultimo_endereco = chg_val;
         if (c <= last) @(negedge clock);
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      iniciar = 1'b0;
      ultimo_endereco = 4'd0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      total++;
      if ({db_estado, leds, mem_addr, fim, ocupado} !== 13'd0) begin
         bad++;
         $display("FAIL reset state: got est=%0d leds=%b addr=%0d fim=%b ocup=%b want all 0",
                  db_estado, leds, mem_addr, fim, ocupado);
      end
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (db_estado !== 3'd0) begin
         bad++;
         $display("FAIL idle hold: got est=%0d want 0", db_estado);
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 16; i++) ram[i] = 4'd0;
      ram[0] = 4'b0001; ram[1] = 4'b0010; ram[2] = 4'b0100; ram[3] = 4'b1000;
      play("single", 0, 1'b0, 0, 4'd0);
   endtask

   task automatic test_four();
      play("four", 3, 1'b0, 0, 4'd0);
      @(negedge clock);
      total++;
      if (ocupado !== 1'b0 || fim !== 1'b0) begin
         bad++;
         $display("FAIL four idle after: got ocup=%b fim=%b want 0 0", ocupado, fim);
      end
   endtask

   task automatic test_repeat();
      ram[0] = 4'b0010; ram[1] = 4'b0010;
      play("repeat", 1, 1'b0, 0, 4'd0);
   endtask

   task automatic test_back_to_back();
      ram[0] = 4'b0001; ram[1] = 4'b0010; ram[2] = 4'b0100; ram[3] = 4'b1000;
      play("held", 1, 1'b1, 10, 4'd3);
      @(negedge clock);
      total++;
      if (db_estado !== 3'd1 || ocupado !== 1'b1) begin
         bad++;
         $display("FAIL held restart: got est=%0d ocup=%b want 1 1", db_estado, ocupado);
      end
      iniciar = 1'b0;
      pulse_reset();
   endtask

   task automatic test_reset_mid();
      int fims;
      ultimo_endereco = 4'd3;
      iniciar = 1'b1;
      @(posedge clock);
      @(negedge clock);
      iniciar = 1'b0;
      repeat (PER + 3) @(negedge clock);
      total++;
      if (db_estado !== 3'd3 || leds !== 4'b0010) begin
         bad++;
         $display("FAIL mid setup: got est=%0d leds=%b want 3 0010", db_estado, leds);
      end
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      total++;
      if (db_estado !== 3'd0 || leds !== 4'd0 || ocupado !== 1'b0 || fim !== 1'b0 || mem_addr !== 4'd0) begin
         bad++;
         $display("FAIL mid reset: got est=%0d leds=%b ocup=%b fim=%b addr=%0d want 0 0 0 0 0",
                  db_estado, leds, ocupado, fim, mem_addr);
      end
      fims = 0;
      repeat (40) begin
         @(negedge clock);
         if (fim === 1'b1) fims++;
      end
      total++;
      if (fims != 0) begin
         bad++;
         $display("FAIL mid no fim: got %0d pulses want 0", fims);
      end
      play("replay", 0, 1'b0, 0, 4'd0);
   endtask

   task automatic test_all16();
      for (int i = 0; i < 16; i++) ram[i] = 4'(1 << (i % 4));
      ram[5] = 4'd0;
      play("all16", 15, 1'b0, 0, 4'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 4'd0;
      reset = 1'b0;
      iniciar = 1'b0;
      ultimo_endereco = 4'd0;
      test_reset();
      test_single();
      test_four();
      test_repeat();
      test_back_to_back();
      test_reset_mid();
      test_all16();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard leftover: got %0d want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
